// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display: binary-to-BCD/hex converter driving DIGITS seven-segment digits.
// Decimal conversion uses serial double-dabble; hex mode bypasses it.
module seg7_bcd_display #(
    parameter int DIGITS     = 6,
    parameter int WIDTH      = 20,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int NIB = (WIDTH * 30103 + 99999) / 100000 + 1;
    localparam int BCDW = 4 * NIB;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [6:0] BLANK = ACTIVE_LOW != 0 ? 7'b1111111 : 7'b0000000;
    localparam logic [6:0] DASH = ACTIVE_LOW != 0 ? 7'b0111111 : 7'b1000000;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                r_state, w_next;
    logic [WIDTH-1:0]      r_bin;
    logic [BCDW-1:0]       r_bcd, w_adj;
    logic [CW-1:0]         r_cnt;
    logic                  r_hex_mode, r_blank_lz, r_ovf;
    logic [7*DIGITS-1:0]   r_hex, w_hex;
    logic [BCDW+WIDTH-1:0] w_sh;
    logic [63:0]           w_src;
    logic                  w_accept, w_ovf;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        return ACTIVE_LOW != 0 ? g : ~g;
    endfunction

    assign w_accept = (r_state == IDLE) && load;
    assign busy     = r_state != IDLE;
    assign overflow = r_ovf;
    assign hex      = r_hex;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = load ? (hex_mode ? UPDATE : SHIFT) : IDLE;
            SHIFT:   w_next = r_cnt == LAST ? UPDATE : SHIFT;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Double-dabble correction: nibbles >= 5 get +3 before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NIB; i++)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end

    assign w_sh  = {w_adj, r_bin} << 1;
    assign w_src = r_hex_mode ? 64'(r_bin) : 64'(r_bcd);
    assign w_ovf = |(w_src >> (4 * DIGITS));

    // Without overflow the source is zero above DIGITS, so a zero tail means a leading zero
    always_comb begin
        w_hex = '0;
        for (int k = 0; k < DIGITS; k++)
            w_hex[7*k +: 7] = w_ovf ? DASH :
                              (r_blank_lz && k != 0 && (w_src >> (4 * k)) == 64'd0) ? BLANK :
                              f_glyph(w_src[4*k +: 4]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_hex_mode <= 1'b0;
            r_blank_lz <= 1'b0;
            r_ovf      <= 1'b0;
            r_hex      <= {DIGITS{BLANK}};
        end else if (w_accept) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_hex_mode <= hex_mode;
            r_blank_lz <= blank_lz;
        end else if (r_state == SHIFT) begin
            r_bcd <= w_sh[BCDW+WIDTH-1:WIDTH];
            r_bin <= w_sh[WIDTH-1:0];
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == UPDATE) begin
            r_hex <= w_hex;
            r_ovf <= w_ovf;
        end
    end
endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb_seg7_bcd_display: randomized and directed checks against an arithmetic display model.
module tb_seg7_bcd_display;
    localparam int DIGITS = 6;
    localparam int WIDTH  = 20;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                load = 1'b0;
    logic [WIDTH-1:0]    value = '0;
    logic                hex_mode = 1'b0;
    logic                blank_lz = 1'b0;
    logic                busy, overflow;
    logic [7*DIGITS-1:0] hex;

    int total = 0;
    int bad = 0;
    logic [7*DIGITS-1:0] exp_hex;
    logic                exp_ovf;
    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seg7_bcd_display #(.DIGITS(DIGITS), .WIDTH(WIDTH), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .busy(busy), .overflow(overflow), .hex(hex)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Display rules straight from arithmetic: digit k = (v / base^k) % base
    task automatic model(input longint v, input bit hm, input bit blz);
        longint base = hm ? 16 : 10;
        longint p = 1;
        for (int k = 0; k < DIGITS; k++) p *= base;
        exp_ovf = v >= p;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            exp_hex[7*k +: 7] = exp_ovf ? 7'b0111111 :
                                (blz && k > 0 && v < p) ? 7'b1111111 : glyph[(v / p) % base];
            p *= base;
        end
    endtask

    task automatic run(input logic [WIDTH-1:0] v, input bit hm, input bit blz, input int junk_at);
        int lat = hm ? 1 : WIDTH + 1;
        logic [7*DIGITS-1:0] prev = exp_hex;
        logic prev_ovf = exp_ovf;
        @(negedge clk);
        load = 1'b1; value = v; hex_mode = hm; blank_lz = blz;
        @(negedge clk);
        for (int i = 0; i < lat; i++) begin
            chk("busy_hi", 64'(busy), 64'd1);
            chk("hex_hold", 64'(hex), 64'(prev));
            chk("ovf_hold", 64'(overflow), 64'(prev_ovf));
            load = (i == junk_at) || (i == lat - 1);
            value = WIDTH'($urandom);
            hex_mode = 1'($urandom);
            blank_lz = 1'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        model(longint'(v), hm, blz);
        chk("hex", 64'(hex), 64'(exp_hex));
        chk("ovf", 64'(overflow), 64'(exp_ovf));
        chk("busy_lo", 64'(busy), 64'd0);
        @(negedge clk);
        chk("no_queue", 64'(busy), 64'd0);
        chk("hex_keep", 64'(hex), 64'(exp_hex));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_hex", 64'(hex), 64'(42'h3ff_ffff_ffff));
        exp_hex = '1;
        exp_ovf = 1'b0;
        rst_n = 1'b1;
        run(20'd123456, 1'b0, 1'b0, 3);
        chk("d123456", 64'(hex), {22'd0, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010});
        run(20'd999999, 1'b0, 1'b0, 5);
        run(20'd1000000, 1'b0, 1'b1, 0);
        chk("d1000000_ovf", 64'(overflow), 64'd1);
        run(20'd42, 1'b0, 1'b1, 7);
        run(20'd0, 1'b0, 1'b1, 1);
        run(20'd0, 1'b0, 1'b0, 1);
        run(20'hABCDE, 1'b1, 1'b0, 0);
        chk("hABCDE", 64'(hex), {22'd0, 7'b1000000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110});
        run(20'h000F0, 1'b1, 1'b1, 0);
        run(20'd5, 1'b0, 1'b0, 2);
        // Reset mid-conversion: nothing of the aborted value may surface
        @(negedge clk);
        load = 1'b1; value = 20'd5; hex_mode = 1'b0; blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        chk("abort_hex", 64'(hex), 64'(42'h3ff_ffff_ffff));
        exp_hex = '1;
        exp_ovf = 1'b0;
        for (int i = 0; i < WIDTH + 5; i++) begin
            @(negedge clk);
            chk("abort_stay", 64'(hex), 64'(42'h3ff_ffff_ffff));
        end
        run(20'd5, 1'b0, 1'b1, 4);
        repeat (80) begin
            logic [WIDTH-1:0] v;
            bit hm;
            v = $urandom_range(0, 3) == 0 ? WIDTH'($urandom_range(0, 999)) : WIDTH'($urandom);
            hm = 1'($urandom);
            run(v, hm, 1'($urandom), hm ? 0 : int'($urandom_range(0, WIDTH)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
